// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
//
// Conditions asynchronous board-level inputs ahead of the gpio block's gpio_i port.
// Each bit is synchronised into the clock domain through a SYNC_STAGES-deep flop chain,
// then debounced. A change is accepted only after it has been stable for a
// run-time programmable number of consecutive cycles.
// The block also produces per-bit edge pulses, sticky pending flags and an aggregate IRQ.
//
// Ports
//   clock      in   1              single clock for the whole block
//   reset      in   1              synchronous, active-high reset
//   raw_i      in   WIDTH          asynchronous pad inputs
//   threshold  in   COUNTER_WIDTH  stable cycles needed to accept a change (0 acts as 1)
//   rise_en    in   WIDTH          per-bit enable: rising edge sets pending
//   fall_en    in   WIDTH          per-bit enable: falling edge sets pending
//   clear_i    in   WIDTH          per-bit pending clear strobe
//   clean_o    out  WIDTH          debounced level, drives gpio.gpio_i
//   rise_o     out  WIDTH          1-cycle pulse on clean_o 0->1
//   fall_o     out  WIDTH          1-cycle pulse on clean_o 1->0
//   pending_o  out  WIDTH          sticky enabled-edge flags
//   irq_o      out  1              OR of pending_o

module gpio_input_conditioner #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         raw_i,
    input  logic [COUNTER_WIDTH-1:0] threshold,
    input  logic [WIDTH-1:0]         rise_en,
    input  logic [WIDTH-1:0]         fall_en,
    input  logic [WIDTH-1:0]         clear_i,
    output logic [WIDTH-1:0]         clean_o,
    output logic [WIDTH-1:0]         rise_o,
    output logic [WIDTH-1:0]         fall_o,
    output logic [WIDTH-1:0]         pending_o,
    output logic                     irq_o
);

    // Synchroniser chain: index 0 samples the pad, index SYNC_STAGES-1 is the synchronised value.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;

    logic [WIDTH-1:0][COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]                    clean_q, clean_d;
    logic [WIDTH-1:0]                    rise_q, rise_d;
    logic [WIDTH-1:0]                    fall_q, fall_d;
    logic [WIDTH-1:0]                    pending_q, pending_d;

    // One extra bit so that cnt + 1 cannot overflow in the compare.
    logic [COUNTER_WIDTH:0] thr_eff;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign thr_eff = (threshold == '0) ? {{COUNTER_WIDTH{1'b0}}, 1'b1} : {1'b0, threshold};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Debounce: count consecutive mismatch cycles and accept once the count reaches
    // the threshold. Any matching cycle discards a partial count, so glitches are rejected.
    always_comb begin
        logic [COUNTER_WIDTH:0] cnt_inc;
        cnt_inc = '0;
        clean_d = clean_q;
        cnt_d   = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_inc = {1'b0, cnt_q[i]} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
            if (sync[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_inc >= thr_eff) begin
                clean_d[i] = sync[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_inc[COUNTER_WIDTH-1:0];
            end
        end
    end

    // Edge pulses are registered together with the new level.
    always_comb begin
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
    end

    // Pending uses the registered pulses, so it trails clean_o by one edge; set beats clear.
    always_comb begin
        pending_d = (pending_q & ~clear_i) | (rise_q & rise_en) | (fall_q & fall_en);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            clean_q   <= RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            pending_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
        end
    end

    assign clean_o   = clean_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pending_o = pending_q;
    assign irq_o     = |pending_q;

endmodule

// File: doc/gpio_input_conditioner.md
# gpio_input_conditioner

Input conditioning stage placed directly upstream of the `gpio` block's `gpio_i` port. It synchronises asynchronous board-level inputs into the `clock` domain and debounces each bit with a run-time programmable threshold. It produces a clean registered level vector to drive `gpio_i`, plus per-bit edge pulses, sticky pending flags and an aggregate interrupt request.

## Interface

**Parameters**
- `WIDTH`, 8: number of input bits; must match `gpio` `INPUT_WIDTH`.
- `COUNTER_WIDTH`, 16: width of the per-bit debounce counters and of `threshold`.
- `SYNC_STAGES`, 2: synchroniser flip-flop depth; minimum 2.
- `RESET_VALUE`, 0: `WIDTH`-bit reset value of the synchroniser chain and of `clean_o`.

**Ports**
- `clock`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous, active-high reset.
- `raw_i`  in  WIDTH: asynchronous pad inputs.
- `threshold`  in  COUNTER_WIDTH: number of consecutive stable cycles needed to accept a change. 0 is treated as 1.
- `rise_en`  in  WIDTH: per-bit enable for setting pending on a rising edge.
- `fall_en`  in  WIDTH: per-bit enable for setting pending on a falling edge.
- `clear_i`  in  WIDTH: per-bit pending clear, 1-cycle strobe.
- `clean_o`  out  WIDTH: debounced level; connects to `gpio.gpio_i`.
- `rise_o`  out  WIDTH: 1-cycle pulse asserted when `clean_o` bit goes 0→1.
- `fall_o`  out  WIDTH: 1-cycle pulse asserted when `clean_o` bit goes 1→0.
- `pending_o`  out  WIDTH: sticky enabled-edge flags.
- `irq_o`  out  1: OR-reduction of `pending_o`.

## Operation

- **Synchroniser:** a `SYNC_STAGES`-deep flip-flop chain per bit. `sync` is the last stage.
- **Debounce:** each bit has an independent counter `cnt`.
  - `sync == clean`: `cnt` ← 0.
  - `sync != clean` and `cnt + 1 >= max(threshold, 1)`: `clean` ← `sync`, `cnt` ← 0.
  - Otherwise: `cnt` ← `cnt + 1`.
  - The compare is `>=`, so lowering `threshold` mid-count accepts on the next mismatch cycle. Raising it extends the wait.
  - `cnt` never wraps, because it clears on acceptance.
- **Glitch rejection:** a mismatch that ends before the threshold is reached clears `cnt`, and `clean_o` is unchanged.
- **Edges:** `rise_o`/`fall_o` are registered in the same edge as the `clean_o` update, from old/new `clean`. At most one of the two is set per bit per cycle.
- **Pending:** per bit, `pending` ← 1 on (`rise_o & rise_en`) | (`fall_o & fall_en`).
  - `clear_i` clears the bit.
  - A set and a clear in the same cycle: set wins.
  - Enables are sampled in the cycle the edge pulse is asserted.
- **IRQ:** `irq_o = |pending_o`. It is combinational from registers, with no extra latency.
- **Reset values:**
  - Synchroniser stages and `clean_o` = `RESET_VALUE`.
  - `cnt`, `rise_o`, `fall_o`, `pending_o` = 0.
  - `irq_o` = 0.
- **Reset mid-debounce:** in-progress counts are discarded, and no edge is emitted for the aborted transition.
- **After reset release:** a `raw_i` value that differs from `RESET_VALUE` is debounced normally and then produces a real edge.

## Timing

- Edge 1 is the first `clock` edge sampling a new stable `raw_i` bit value.
- `clean_o`, `rise_o`/`fall_o` update at edge `SYNC_STAGES + max(threshold, 1)`.
  - Example: defaults with threshold 4 gives edge 6.
- `pending_o` and `irq_o` follow one edge later.
- `rise_o`/`fall_o` are high for exactly one cycle.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.

## Test plan

- **Reset/release:** `raw_i`=8'h00, reset asserted then released. All outputs stay 0 and no pulses occur.
- **Debounce latency:** `threshold`=4, `raw_i`: 8'h00→8'hFE held.
  - `clean_o` becomes 8'hFE at edge 6.
  - `rise_o`=8'hFE for one cycle.
  - `fall_o`=0.
- **Glitch reject:** `threshold`=4, `raw_i[0]` high for 3 cycles then low. `clean_o[0]` stays 0 and `rise_o[0]` is never set.
- **Pending/irq:** `rise_en`=8'h01, `fall_en`=8'h80.
  - A rise on bit 0 sets `pending_o`=8'h01 and `irq_o`=1.
  - `clear_i`=8'h01 coincident with a bit-7 fall gives `pending_o`=8'h80.
  - A set and clear on the same bit in the same cycle leaves the bit set.
- **Threshold 0:** `threshold`=0, bit 3 0→1. `clean_o[3]` changes at edge 3, identical to `threshold`=1.
- **Mid-operation reset:** `threshold`=100, `raw_i`=8'hFF for 50 cycles, then a 1-cycle `reset`.
  - Counters restart from 0.
  - `clean_o` stays 0 until 100 cycles after `sync` is valid again.
  - `pending_o` is 0 throughout.
